// File: rtl/switch_sequencer_if.sv
// Host-side bundle for switch_sequencer: table load handshake, run control and status.
interface switch_sequencer_if #(
   parameter int unsigned TW = 16
);
   logic          load_valid;
   logic [TW-1:0] load_time;
   logic          load_ready;
   logic          clr;
   logic          start;
   logic          abort;
   logic          ctrl;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      output load_valid, load_time, clr, start, abort,
      input  load_ready, ctrl, busy, done, err
   );

   modport slave (
      input  load_valid, load_time, clr, start, abort,
      output load_ready, ctrl, busy, done, err
   );
endinterface

// File: rtl/switch_sequencer.sv
// Timing generator: toggles a control level at each programmed tick of a strictly
// increasing time table, driving the controlling node of the switch/relay stage.
module switch_sequencer #(
   parameter int unsigned TW    = 16,
   parameter int unsigned DEPTH = 8,
   parameter bit          INIT  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   switch_sequencer_if.slave bus
);
   localparam int unsigned   CW   = $clog2(DEPTH + 1);
   localparam int unsigned   IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {StIdle, StRun} state_e;

   state_e        r_state, w_state_d;
   logic [CW-1:0] r_count, w_count_d;
   logic [IW-1:0] r_idx, w_idx_d;
   logic [TW-1:0] r_timer, w_timer_d;
   logic          r_ctrl, w_ctrl_d;
   logic          r_busy, w_busy_d;
   logic          r_done, w_done_d;
   logic          r_err, w_err_d;
   logic [TW-1:0] r_table [DEPTH];

   logic          w_load_ready;
   logic          w_wr_en;
   logic          w_match;
   logic          w_last;
   logic [IW-1:0] w_wr_idx;
   logic [IW-1:0] w_prev_idx;
   logic [TW-1:0] w_prev_time;

   assign w_wr_idx     = r_count[IW-1:0];
   assign w_prev_idx   = w_wr_idx - IW'(1);
   assign w_prev_time  = r_table[w_prev_idx];
   assign w_match      = (r_timer == r_table[r_idx]);
   assign w_last       = (CW'(r_idx) == (r_count - CW'(1)));
   assign w_load_ready = (r_state == StIdle) && (r_count < FULL) && !bus.clr && !bus.start;

   always_comb begin
      w_state_d = r_state;
      w_count_d = r_count;
      w_idx_d   = r_idx;
      w_timer_d = r_timer;
      w_ctrl_d  = r_ctrl;
      w_busy_d  = r_busy;
      w_done_d  = 1'b0;
      w_err_d   = r_err;
      w_wr_en   = 1'b0;
      case (r_state)
         StIdle: begin
            if (bus.clr) begin
               w_count_d = '0;
               w_err_d   = 1'b0;
            end else if (bus.start) begin
               if (r_count != '0) begin
                  w_state_d = StRun;
                  w_timer_d = '0;
                  w_idx_d   = '0;
                  w_ctrl_d  = INIT;
               end
            end else if (bus.load_valid && w_load_ready) begin
               // Non-increasing times complete the handshake but are dropped.
               if ((r_count == '0) || (bus.load_time > w_prev_time)) begin
                  w_wr_en   = 1'b1;
                  w_count_d = r_count + CW'(1);
               end else begin
                  w_err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (bus.abort) begin
               w_state_d = StIdle;
               w_ctrl_d  = INIT;
               w_busy_d  = 1'b0;
            end else if (!r_busy) begin
               // Arming cycle after start: timer held at 0, busy rises next edge.
               w_busy_d = 1'b1;
            end else begin
               w_timer_d = r_timer + TW'(1);
               if (w_match) begin
                  w_ctrl_d = ~r_ctrl;
                  w_idx_d  = r_idx + IW'(1);
                  if (w_last) begin
                     w_state_d = StIdle;
                     w_busy_d  = 1'b0;
                     w_done_d  = 1'b1;
                  end
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_count <= '0;
         r_idx   <= '0;
         r_timer <= '0;
         r_ctrl  <= INIT;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_count <= w_count_d;
         r_idx   <= w_idx_d;
         r_timer <= w_timer_d;
         r_ctrl  <= w_ctrl_d;
         r_busy  <= w_busy_d;
         r_done  <= w_done_d;
         r_err   <= w_err_d;
      end
   end

   // Table storage needs no reset: r_count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_table[w_wr_idx] <= bus.load_time;
      end
   end

   assign bus.load_ready = w_load_ready;
   assign bus.ctrl       = r_ctrl;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
endmodule
